// File: rtl/add_sub_pkg.sv
// Shared types and constants for the multi-cycle add/sub block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_sub_pkg;

  // FSM encoding shared by the datapath and anyone decoding debug state.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of chunk steps for one operation.
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk build still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturation limits for a WIDTH-bit signed value (WIDTH <= 64).
  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/add_sub_multicycle_if.sv
// Operand/result handshake bundle for add_sub_multicycle.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control.
interface add_sub_multicycle_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  // Producer/consumer side: presents operands, takes results.
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero
  );
endinterface

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit add/sub slice: a + (b ^ {sub}) + cin.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller sequences the slice.
module add_sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK-1:0] b_x;
  logic [CHUNK:0]   full;

  // One ripple step; the carry into the top bit falls out of sum^a^b at that bit.
  always_comb begin
    b_x      = b ^ {CHUNK{sub}};
    full     = {1'b0, a} + {1'b0, b_x} + {{CHUNK{1'b0}}, cin};
    sum      = full[CHUNK-1:0];
    cout     = full[CHUNK];
    c_msb_in = full[CHUNK-1] ^ a[CHUNK-1] ^ b_x[CHUNK-1];
  end
endmodule

// File: rtl/add_sub_multicycle.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock; optional ADDSUB_SAT_EN saturation.
// Latency: out_valid rises NCHUNK cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module add_sub_multicycle
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                clk,
  input logic                reset_n,
  add_sub_multicycle_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             sub_r;
  logic             c_r;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;

  // Result registers stay separate from the accumulator so the visible
  // sum keeps its last value while the next operation is in flight.
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;
  logic             zero_r;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_cmsb;
  logic [WIDTH-1:0] final_sum;
  logic [WIDTH-1:0] res_sum;
  logic             ovf_now;

  // The single slice is time-multiplexed over the latched operands.
  add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_r[idx*CHUNK +: CHUNK]),
    .b        (b_r[idx*CHUNK +: CHUNK]),
    .sub      (sub_r),
    .cin      (c_r),
    .sum      (ch_sum),
    .cout     (ch_cout),
    .c_msb_in (ch_cmsb)
  );

  // Assemble the complete sum as it will look once the current chunk lands.
  always_comb begin
    final_sum                      = acc;
    final_sum[idx*CHUNK +: CHUNK]  = ch_sum;
    ovf_now                        = ch_cmsb ^ ch_cout;
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));

  // Clamp toward the sign of A whenever signed overflow occurs.
  always_comb begin
    res_sum = final_sum;
    if (ovf_now) res_sum = a_r[WIDTH-1] ? MIN_NEG : MAX_POS;
  end
`else
  // Plain modulo-2^WIDTH result.
  always_comb begin
    res_sum = final_sum;
  end
`endif

  // Handshake outputs decode directly from state.
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
    bus.sum       = sum_r;
    bus.carry     = carry_r;
    bus.overflow  = ovf_r;
    bus.zero      = zero_r;
  end

  // Sequencer: latch operands, ripple one chunk per cycle, hold the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      c_r     <= 1'b0;
      idx     <= '0;
      acc     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            sub_r <= bus.sub;
            c_r   <= bus.sub;  // +1 of the two's-complement negate
            idx   <= '0;
            acc   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          acc[idx*CHUNK +: CHUNK] <= ch_sum;
          c_r                     <= ch_cout;
          if (idx == LAST_IDX) begin
            sum_r   <= res_sum;
            carry_r <= ch_cout ^ sub_r;  // borrow is the inverted carry for subtract
            ovf_r   <= ovf_now;
            zero_r  <= (res_sum == '0);
            state   <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_sub_multicycle.sv
// Directed bench for add_sub_multicycle at WIDTH=16, CHUNK=4.
// Latency: expects out_valid 4 cycles after accept.
// Backpressure: exercises a 6-cycle out_ready stall and a mid-CALC reset.
module tb_add_sub_multicycle;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  add_sub_multicycle_if #(.WIDTH(16)) bus ();

  add_sub_multicycle #(.WIDTH(16), .CHUNK(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation and return #1 after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(posedge clk); #1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count cycles from accept to out_valid, bounded.
  task automatic wait_done(input string tag);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 4);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] s, input logic c,
                         input logic v, input logic z);
    chk({tag, "_res"}, {13'd0, bus.sum, bus.carry, bus.overflow, bus.zero}, {13'd0, s, c, v, z});
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] es, input logic ec,
                        input logic ev, input logic ez);
    start_op(a, b, s);
    wait_done(tag);
    chk_res(tag, es, ec, ev, ez);
    retire(tag);
  endtask

  initial begin
    logic [18:0] held;
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("reset_state", {bus.in_ready, bus.out_valid, bus.sum, bus.carry, bus.overflow, bus.zero},
        {1'b1, 1'b0, 16'h0000, 3'b000});
    reset_n = 1'b1;

    run_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    run_op("sub_pos",  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
`else
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`endif

    // Stall in DONE while the producer side wiggles.
    bus.out_ready = 1'b0;
    start_op(16'h0005, 16'h0003, 1'b1);
    wait_done("hold");
    chk_res("hold", 16'h0002, 1'b0, 1'b0, 1'b0);
    held = {bus.sum, bus.carry, bus.overflow, bus.zero};
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.sub      = ~bus.sub;
      @(posedge clk); #1;
      chk("hold_stable", {13'd0, bus.sum, bus.carry, bus.overflow, bus.zero}, {13'd0, held});
      chk("hold_hs", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b0, 1'b1});
    end
    bus.in_valid = 1'b0;
    retire("hold");
    @(posedge clk); #1;
    chk("hold_nocap", {12'd0, bus.in_ready, bus.sum, bus.carry, bus.overflow, bus.zero},
        {12'd0, 1'b1, 16'h0002, 3'b000});

    // Abort mid-CALC with an asynchronous reset.
    start_op(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_async", {bus.in_ready, bus.out_valid, bus.sum, bus.carry, bus.overflow, bus.zero},
        {1'b1, 1'b0, 16'h0000, 3'b000});
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_nopartial", {30'd0, bus.in_ready, bus.out_valid}, {30'd0, 1'b1, 1'b0});
    end
    run_op("post_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
